// File: rtl/im.sv
// Single-port 1024x16 working memory with registered, write-first read.
// Optional IM_RESET_CLEAR_EN: reset also zeroes every memory word.
module im #(
  parameter int MEMORY_SIZE      = 1024,
  parameter int MEMORY_ADDR_SIZE = 10,
  parameter int MEMORY_DATA_SIZE = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        readEn,
  input  logic                        writeEn,
  input  logic                        mux_sel,
  input  logic [MEMORY_ADDR_SIZE-1:0] address,
  input  logic [MEMORY_DATA_SIZE-1:0] data_ALU,
  input  logic [MEMORY_DATA_SIZE-1:0] data_Reg,
  output logic [MEMORY_DATA_SIZE-1:0] dataOut
);

  logic [MEMORY_DATA_SIZE-1:0] mem [MEMORY_SIZE];
  logic [MEMORY_DATA_SIZE-1:0] wdata;
  logic                        in_range;

  assign wdata = mux_sel ? data_Reg : data_ALU;

  // Range check only exists when the address space exceeds the array.
  generate
    if (MEMORY_SIZE < (2 ** MEMORY_ADDR_SIZE)) begin : g_range
      assign in_range = (32'(address) < MEMORY_SIZE);
    end else begin : g_full
      assign in_range = 1'b1;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      dataOut <= '0;
`ifdef IM_RESET_CLEAR_EN
      for (int unsigned i = 0; i < MEMORY_SIZE; i++) begin
        mem[i[MEMORY_ADDR_SIZE-1:0]] <= '0;
      end
`endif
    end else begin
      if (writeEn && in_range) begin
        mem[address] <= wdata;
      end
      // Shared address: a colliding read returns the data being written.
      if (readEn) begin
        if (!in_range) begin
          dataOut <= '0;
        end else if (writeEn) begin
          dataOut <= wdata;
        end else begin
          dataOut <= mem[address];
        end
      end
    end
  end

endmodule

// File: tb/tb_im.sv
// Self-checking bench for im: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_im;

  logic        clk = 1'b0;
  logic        rst;
  logic        readEn;
  logic        writeEn;
  logic        mux_sel;
  logic [9:0]  address;
  logic [15:0] data_ALU;
  logic [15:0] data_Reg;
  logic [15:0] dataOut;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] model [1024];
  bit          known [1024];
  logic [15:0] exp_out;
  bit          exp_known;

  always #5 clk = ~clk;

  im #(
    .MEMORY_SIZE(1024),
    .MEMORY_ADDR_SIZE(10),
    .MEMORY_DATA_SIZE(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .readEn(readEn),
    .writeEn(writeEn),
    .mux_sel(mux_sel),
    .address(address),
    .data_ALU(data_ALU),
    .data_Reg(data_Reg),
    .dataOut(dataOut)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive at negedge, update model, compare after the edge.
  task automatic cycle(input string tag, input bit r, input bit re, input bit we,
                       input bit sel, input int addr, input logic [15:0] alu,
                       input logic [15:0] rg);
    logic [15:0] wd;
    @(negedge clk);
    rst = r; readEn = re; writeEn = we; mux_sel = sel;
    address = 10'(addr); data_ALU = alu; data_Reg = rg;
    @(posedge clk);
    #1;
    wd = sel ? rg : alu;
    if (r) begin
      exp_out = 16'h0000;
      exp_known = 1'b1;
`ifdef IM_RESET_CLEAR_EN
      for (int k = 0; k < 1024; k++) begin
        model[k] = 16'h0000;
        known[k] = 1'b1;
      end
`endif
    end else begin
      if (we) begin
        model[addr] = wd;
        known[addr] = 1'b1;
      end
      if (re) begin
        exp_out = model[addr];
        exp_known = known[addr];
      end
    end
    if (exp_known) check(tag, dataOut, exp_out);
  endtask

  initial begin
    for (int k = 0; k < 1024; k++) known[k] = 1'b0;
    exp_known = 1'b0;
    exp_out = '0;
    rst = 1'b0; readEn = 1'b0; writeEn = 1'b0; mux_sel = 1'b0;
    address = '0; data_ALU = '0; data_Reg = '0;

    // Reset with a concurrent write request: write discarded, dataOut cleared.
    cycle("reset", 1, 0, 1, 0, 0, 16'h0004, 16'h0000);
    check("reset_out", dataOut, 16'h0000);
`ifdef IM_RESET_CLEAR_EN
    cycle("reset_clear_rd", 0, 1, 0, 0, 777, 16'h0, 16'h0);
    check("reset_clear_val", dataOut, 16'h0000);
`endif

    // ALU-source write then read.
    cycle("alu_wr", 0, 0, 1, 0, 0, 16'h0004, 16'h0007);
    cycle("alu_rd", 0, 1, 0, 0, 0, 16'h0000, 16'h0000);
    check("alu_rd_val", dataOut, 16'h0004);

    // Write-first collision with register source.
    cycle("collide", 0, 1, 1, 1, 0, 16'h0004, 16'h0007);
    check("collide_val", dataOut, 16'h0007);
    cycle("collide_mem", 0, 1, 0, 0, 0, 16'h0, 16'h0);
    check("collide_mem_val", dataOut, 16'h0007);

    // Hold: readEn low with changing address and data.
    for (int k = 0; k < 3; k++) begin
      cycle("hold", 0, 0, 0, k[0], 100 + k, 16'h1111 * 16'(k + 1), 16'h2222);
      check("hold_val", dataOut, 16'h0007);
    end

    // Address boundary.
    cycle("bnd_wr_hi", 0, 0, 1, 0, 1023, 16'hBEEF, 16'h0000);
    cycle("bnd_wr_lo", 0, 0, 1, 1, 0, 16'hFFFF, 16'h1234);
    cycle("bnd_rd_hi", 0, 1, 0, 0, 1023, 16'h0, 16'h0);
    check("bnd_hi_val", dataOut, 16'hBEEF);
    cycle("bnd_rd_lo", 0, 1, 0, 0, 0, 16'h0, 16'h0);
    check("bnd_lo_val", dataOut, 16'h1234);

    // Reset mid-operation: write during reset is dropped.
    cycle("mid_pre", 0, 0, 1, 0, 5, 16'h5555, 16'h0000);
    cycle("mid_rst", 1, 1, 1, 0, 5, 16'hAAAA, 16'hAAAA);
    check("mid_rst_out", dataOut, 16'h0000);
    cycle("mid_rd", 0, 1, 0, 0, 5, 16'h0, 16'h0);
`ifdef IM_RESET_CLEAR_EN
    check("mid_rd_val", dataOut, 16'h0000);
`else
    check("mid_rd_val", dataOut, 16'h5555);
`endif

    // Randomized traffic over a small hot set plus the extremes.
    for (int n = 0; n < 3000; n++) begin
      int a;
      int pick;
      pick = $urandom_range(0, 9);
      if (pick == 0)      a = 0;
      else if (pick == 1) a = 1023;
      else if (pick < 7)  a = $urandom_range(0, 15);
      else                a = $urandom_range(0, 1023);
      cycle("rand", ($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, a,
            16'($urandom), 16'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
